fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 current_pc  in  32  current value from the PC register.
REQ-004 pc_load  out  1  PC register load strobe, one cycle.
REQ-005 next_pc  out  32  value the PC register loads when pc_load=1.
REQ-006 mem_req  out  1  instruction memory read request, level.
REQ-007 mem_addr  out  32  read address; stable while mem_req=1.
REQ-008 mem_ready  in  1  memory returns mem_rdata this cycle.
REQ-009 mem_rdata  in  32  instruction word, valid only when mem_ready=1.
REQ-010 instr_valid  out  1  fetched instruction offered to decode.
REQ-011 instr  out  32  fetched instruction word.
REQ-012 instr_pc  out  32  address of instr.
REQ-013 instr_ready  in  1  decode accepts instr this cycle.
REQ-014 redirect_valid  in  1  branch/jump/trap redirect from execute.
REQ-015 redirect_pc  in  32  redirect target.
REQ-016 fetch_fault  out  1  misaligned-fetch flag (see Configuration).

Function
REQ-017 FSM states ISSUE, WAIT, HOLD (plus FAULT per REQ-036); one fetch in flight max.
REQ-018 ISSUE: mem_req=0; without redirect, latch req_addr<=current_pc, go WAIT.
REQ-019 WAIT: mem_req=1, mem_addr=req_addr; stay until mem_ready=1.
REQ-020 WAIT & mem_ready & !kill & !redirect_valid: instr<=mem_rdata, instr_pc<=req_addr, pc_load=1, next_pc=req_addr+4 (mod 2^32), go HOLD.
REQ-021 HOLD: instr_valid=1; instr/instr_pc stable; on instr_ready go ISSUE.
REQ-022 Fetch latency: ISSUE 1 cycle + WAIT >=1 cycle; min 2 cycles from ISSUE entry to instr_valid.
REQ-023 pc_load is combinational from state/inputs, high at most one cycle per event; next_pc=0 when pc_load=0.
REQ-024 Redirect any state: pc_load=1, next_pc=redirect_pc same cycle; redirect has priority over every other pc_load source.
REQ-025 Redirect in ISSUE: no latch, stay ISSUE (new PC latched next cycle).
REQ-026 Redirect in WAIT without mem_ready: set kill<=1, stay WAIT, mem_addr unchanged.
REQ-027 WAIT & mem_ready & (kill | redirect_valid): data discarded, kill<=0, no HOLD, go ISSUE.
REQ-028 Redirect in HOLD: instr_valid forced 0 that cycle, instr dropped even if instr_ready=1, go ISSUE.
REQ-029 instr_valid = (state==HOLD) & !redirect_valid.
REQ-030 Back-to-back redirects: each cycle's redirect_pc overwrites the previous; only last one fetched.

Reset
REQ-031 reset=1 at clock edge: state<=ISSUE, kill<=0, req_addr<=0, instr<=0, instr_pc<=0, fetch_fault<=0.
REQ-032 While reset=1: mem_req=0, instr_valid=0, pc_load=0, next_pc=0.
REQ-033 Reset mid-WAIT abandons the access; late mem_ready after reset is ignored in ISSUE.
REQ-034 First fetch after reset release uses current_pc as then presented.

Configuration
REQ-035 Macro FETCH_MISALIGN_CHECK_EN selects misaligned-fetch checking.
REQ-036 Defined: in ISSUE, current_pc[1:0]!=0 -> no request, fetch_fault<=1, go FAULT; FAULT holds mem_req=0, instr_valid=0 until redirect_valid (clears fault, acts per REQ-024, go ISSUE) or reset.
REQ-037 Not defined: fetch_fault tied 0, no FAULT state, mem_addr={req_addr[31:2],2'b00}.

Verification
REQ-038 Reset, current_pc=0x0, mem_ready one cycle after mem_req, rdata=0x00500093 -> mem_addr=0x0, pc_load with next_pc=0x4, instr_valid with instr=0x00500093, instr_pc=0x0.
REQ-039 mem_ready delayed 3 cycles -> mem_req and mem_addr stable 3 cycles, single pc_load, no duplicate instr.
REQ-040 Redirect to 0x100 in WAIT, mem_ready next cycle -> pc_load next_pc=0x100, returned word discarded, next mem_addr=0x100.
REQ-041 HOLD with instr_ready=0 for 4 cycles, then redirect_valid=1 and instr_ready=1 same cycle -> instr_valid=0, instr dropped, next fetch at redirect_pc.
REQ-042 Reset asserted during WAIT, mem_ready arrives after reset -> no instr_valid, no pc_load, fresh fetch from current_pc.
REQ-043 FETCH_MISALIGN_CHECK_EN defined, current_pc=0x102 -> fetch_fault=1, mem_req=0; redirect to 0x200 clears fault and fetches 0x200; undefined -> mem_addr=0x100, fetch_fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one fetch in flight, redirect-aware, drives the PC register load strobe.
// Optional misaligned-fetch trapping is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic        pc_load,
  output logic [31:0] next_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;
`endif

  state_t            state_q, state_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              fault_q, fault_d;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_ISSUE;
      kill_q     <= 1'b0;
      req_addr_q <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  // Next-state and strobe logic
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    req_addr_d  = req_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d     = fault_q;
`endif
    pc_load     = 1'b0;
    next_pc     = '0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;

    case (state_q)
      S_ISSUE: begin
        if (!redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (current_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            req_addr_d = current_pc;
            state_d    = S_WAIT;
          end
`else
          req_addr_d = current_pc;
          state_d    = S_WAIT;
`endif
        end
      end
      S_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          // A pending or same-cycle redirect makes the returning word stale
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_ISSUE;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = req_addr_q;
            pc_load    = 1'b1;
            next_pc    = req_addr_q + INSTR_BYTES;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        instr_valid = !redirect_valid;
        if (redirect_valid || instr_ready) begin
          state_d = S_ISSUE;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      S_FAULT: begin
        if (redirect_valid) begin
          fault_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
`endif
      default: state_d = S_ISSUE;
    endcase

    // Redirect wins over the sequential PC update in every state
    if (redirect_valid) begin
      pc_load = 1'b1;
      next_pc = redirect_pc;
    end

    if (reset) begin
      pc_load     = 1'b0;
      next_pc     = '0;
      mem_req     = 1'b0;
      instr_valid = 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign mem_addr    = req_addr_q;
  assign fetch_fault = fault_q;
`else
  assign mem_addr    = {req_addr_q[XLEN-1:2], 2'b00};
  assign fetch_fault = 1'b0;
`endif

  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch scenarios with a small memory and PC-register model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] current_pc = 32'h0;
  logic        pc_load;
  logic [31:0] next_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset(reset), .current_pc(current_pc),
    .pc_load(pc_load), .next_pc(next_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int accepts  = 0;
  int req_cycles = 0;
  int last_req_len = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_word_q[$];
  logic [31:0] exp_ipc_q[$];

  bit          mem_auto = 1'b1;
  int          mem_lat  = 0;
  int          wait_cnt = 0;
  logic [31:0] mem_word = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: DUT event with no expected entry", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a request, load or instruction
  initial begin
    logic [31:0] cur_addr;
    bit          in_req;
    bit          prev_rst;
    cur_addr = 32'hFFFF_FFFF;
    in_req   = 1'b0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_pc_load", 32'(pc_load), 32'h0);
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        if (prev_rst) begin
          check("rst_instr", instr, 32'h0);
          check("rst_instr_pc", instr_pc, 32'h0);
          check("rst_fetch_fault", 32'(fetch_fault), 32'h0);
        end
        in_req = 1'b0;
        req_cycles = 0;
      end else begin
        if (mem_req) begin
          if (!in_req) begin
            if (exp_addr_q.size() == 0) begin
              unexpected("mem_req");
              cur_addr = 32'hFFFF_FFFF;
            end else begin
              cur_addr = exp_addr_q.pop_front();
            end
            in_req = 1'b1;
            req_cycles = 0;
          end
          req_cycles++;
          check("mem_addr", mem_addr, cur_addr);
        end else begin
          if (in_req) last_req_len = req_cycles;
          in_req = 1'b0;
        end
        if (pc_load) begin
          if (exp_pc_q.size() == 0) unexpected("pc_load");
          else check("next_pc", next_pc, exp_pc_q.pop_front());
        end
        if (instr_valid && instr_ready) begin
          if (exp_word_q.size() == 0) begin
            unexpected("instr_accept");
          end else begin
            check("instr", instr, exp_word_q.pop_front());
            check("instr_pc", instr_pc, exp_ipc_q.pop_front());
          end
          accepts++;
        end
      end
      prev_rst = reset;
    end
  end

  // One clock: PC register model loads on pc_load, memory model answers after mem_lat wait cycles
  task automatic cycle();
    logic        pl;
    logic [31:0] np;
    @(negedge clock);
    pl = pc_load;
    np = next_pc;
    @(posedge clock);
    #1;
    if (pl) current_pc = np;
    if (mem_auto) begin
      if (mem_req) begin
        if (wait_cnt == mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word;
          wait_cnt  = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wait_cnt  = 0;
      end
    end
  endtask

  task automatic start_test(input logic [31:0] pc, input int lat, input logic [31:0] word);
    reset = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    mem_auto = 1'b1;
    mem_lat = lat;
    mem_word = word;
    cycle();
    cycle();
    current_pc = pc;
    wait_cnt = 0;
  endtask

  task automatic wait_accepts(input int target, input string name);
    int n;
    n = 0;
    while (accepts < target && n < 40) begin
      cycle();
      n++;
    end
    if (accepts < target) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: timeout waiting for instruction accept (got %0d of %0d)", name, accepts, target);
    end
  endtask

  task automatic wait_signal(input bit which_valid, input string name);
    int n;
    n = 0;
    while (!(which_valid ? instr_valid : mem_req) && n < 40) begin
      cycle();
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: timeout waiting for %s", name, which_valid ? "instr_valid" : "mem_req");
    end
  endtask

  initial begin
    int tgt;

    // Basic fetch from reset vector
    start_test(32'h0, 1, 32'h0050_0093);
    exp_addr_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    exp_word_q.push_back(32'h0050_0093); exp_ipc_q.push_back(32'h0);
    tgt = accepts + 1;
    reset = 1'b0;
    wait_accepts(tgt, "basic");
    check("basic_req_len", 32'(last_req_len), 32'd2);

    // Slow memory: request held stable for the whole wait
    start_test(32'h40, 3, 32'h1234_5678);
    exp_addr_q.push_back(32'h40);
    exp_pc_q.push_back(32'h44);
    exp_word_q.push_back(32'h1234_5678); exp_ipc_q.push_back(32'h40);
    tgt = accepts + 1;
    reset = 1'b0;
    wait_accepts(tgt, "slow_mem");
    check("slow_req_len", 32'(last_req_len), 32'd4);

    // Redirect during wait: in-flight word discarded, refetch at target
    start_test(32'h80, 1, 32'hBAD0_BAD0);
    exp_addr_q.push_back(32'h80);
    exp_pc_q.push_back(32'h100);
    exp_addr_q.push_back(32'h100);
    exp_pc_q.push_back(32'h104);
    exp_word_q.push_back(32'h0000_0113); exp_ipc_q.push_back(32'h100);
    tgt = accepts + 1;
    reset = 1'b0;
    wait_signal(1'b0, "redir_wait");
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    mem_word = 32'h0000_0113;
    wait_accepts(tgt, "redir_wait");

    // Stalled hold, then redirect with instr_ready in the same cycle
    start_test(32'h200, 0, 32'hA4A4_A4A4);
    exp_addr_q.push_back(32'h200);
    exp_pc_q.push_back(32'h204);
    exp_pc_q.push_back(32'h300);
    exp_addr_q.push_back(32'h300);
    exp_pc_q.push_back(32'h304);
    exp_word_q.push_back(32'hB5B5_B5B5); exp_ipc_q.push_back(32'h300);
    instr_ready = 1'b0;
    tgt = accepts + 1;
    reset = 1'b0;
    wait_signal(1'b1, "hold_stall");
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 32'(instr_valid), 32'h1);
      check("hold_instr", instr, 32'hA4A4_A4A4);
      check("hold_instr_pc", instr_pc, 32'h200);
      cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    instr_ready = 1'b1;
    mem_word = 32'hB5B5_B5B5;
    #1;
    check("hold_redirect_valid", 32'(instr_valid), 32'h0);
    cycle();
    redirect_valid = 1'b0;
    wait_accepts(tgt, "hold_redirect");

    // Reset mid-wait; late mem_ready after reset must be ignored
    start_test(32'h400, 0, 32'h0);
    mem_auto = 1'b0;
    mem_ready = 1'b0;
    exp_addr_q.push_back(32'h400);
    exp_addr_q.push_back(32'h480);
    exp_pc_q.push_back(32'h484);
    exp_word_q.push_back(32'hC6C6_C6C6); exp_ipc_q.push_back(32'h480);
    tgt = accepts + 1;
    reset = 1'b0;
    wait_signal(1'b0, "reset_wait");
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hEEEE_EEEE;
    current_pc = 32'h480;
    cycle();
    mem_ready = 1'b0;
    mem_lat = 0;
    wait_cnt = 0;
    mem_word = 32'hC6C6_C6C6;
    mem_auto = 1'b1;
    wait_accepts(tgt, "reset_wait");

    // Misaligned PC
    start_test(32'h102, 0, 32'hD7D7_D7D7);
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_pc_q.push_back(32'h200);
    exp_addr_q.push_back(32'h200);
    exp_pc_q.push_back(32'h204);
    exp_word_q.push_back(32'hD7D7_D7D7); exp_ipc_q.push_back(32'h200);
    tgt = accepts + 1;
    reset = 1'b0;
    cycle();
    cycle();
    cycle();
    check("fault_flag", 32'(fetch_fault), 32'h1);
    check("fault_mem_req", 32'(mem_req), 32'h0);
    check("fault_instr_valid", 32'(instr_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    check("fault_cleared", 32'(fetch_fault), 32'h0);
    wait_accepts(tgt, "misalign");
`else
    exp_addr_q.push_back(32'h100);
    exp_pc_q.push_back(32'h106);
    exp_word_q.push_back(32'hD7D7_D7D7); exp_ipc_q.push_back(32'h102);
    tgt = accepts + 1;
    reset = 1'b0;
    cycle();
    check("nofault_flag", 32'(fetch_fault), 32'h0);
    wait_accepts(tgt, "misalign");
    check("nofault_flag_end", 32'(fetch_fault), 32'h0);
`endif

    // next_pc wraps at the top of the address space
    start_test(32'hFFFF_FFFC, 0, 32'hE8E8_E8E8);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'h0);
    exp_word_q.push_back(32'hE8E8_E8E8); exp_ipc_q.push_back(32'hFFFF_FFFC);
    tgt = accepts + 1;
    reset = 1'b0;
    wait_accepts(tgt, "wrap");

    reset = 1'b1;
    cycle();
    cycle();
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'h0);
    check("pc_q_empty", 32'(exp_pc_q.size()), 32'h0);
    check("instr_q_empty", 32'(exp_word_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
